// File: rtl/jt053247_draw.sv
// jt053247_draw: sprite line drawer.
// Answers one scanner draw request at a time: fetches one 16-pixel 4bpp
// tile row as two 32-bit ROM words, then walks it with a 4.6 fixed-point
// horizontal zoom accumulator, emitting one line-buffer pixel per clock.
// Continuation tiles (hz_keep) resume both the accumulator and x position
// where the previous tile of the same sprite stopped.
module jt053247_draw #(
  parameter int BUFW   = 9,
  parameter int MAXPXL = 512
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dr_start,
  output logic            dr_busy,
  input  logic [15:0]     code,
  input  logic [9:0]      attr,
  input  logic            hflip,
  input  logic            vflip,
  input  logic [8:0]      hpos,
  input  logic [3:0]      ysub,
  input  logic [11:0]     hzoom,
  input  logic            hz_keep,
  output logic [20:0]     rom_addr,
  output logic            rom_cs,
  input  logic [31:0]     rom_data,
  input  logic            rom_ok,
  output logic [BUFW-1:0] buf_addr,
  output logic [13:0]     buf_din,
  output logic            buf_we
);

  localparam int CNTW = $clog2(MAXPXL + 1);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} state_t;

  state_t          state_q, state_d;
  logic [15:0]     code_q, code_d;
  logic [9:0]      attr_q, attr_d;
  logic            hflip_q, hflip_d;
  logic [3:0]      yrow_q, yrow_d;
  logic [9:0]      step_q, step_d;
  logic [31:0]     left_q, left_d;
  logic [31:0]     right_q, right_d;
  logic [10:0]     acc_q, acc_d;
  logic [BUFW-1:0] x_q, x_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [10:0]     acc_sum;
  logic [3:0]      src_idx;
  logic [3:0]      pixel;
  logic            last_pxl;
  logic            unused_hzoom;

  // Only the low ten bits of the zoom step are meaningful.
  assign unused_hzoom = ^hzoom[11:10];

  // Source pixel n: left word holds pixels 0..7, right word 8..15,
  // each word packed most-significant nibble first.
  function automatic logic [3:0] pick_pixel(input logic [31:0] lw,
                                            input logic [31:0] rw,
                                            input logic [3:0]  idx);
    logic [31:0] w;
    w = idx[3] ? rw : lw;
    w = w >> {3'd7 - idx[2:0], 2'b00};
    return w[3:0];
  endfunction

  // Integer part of the accumulator selects the source column; flip mirrors it.
  assign src_idx  = hflip_q ? ~acc_q[9:6] : acc_q[9:6];
  assign pixel    = pick_pixel(left_q, right_q, src_idx);
  assign acc_sum  = acc_q + {1'b0, step_q};
  assign last_pxl = (cnt_q == CNTW'(MAXPXL - 1));

  // Outputs decoded from the current state and latched request.
  always_comb begin
    dr_busy  = (state_q != IDLE);
    rom_cs   = (state_q == FETCH0) || (state_q == FETCH1);
    rom_addr = {code_q, yrow_q, state_q == FETCH1};
    buf_addr = x_q;
    buf_din  = {attr_q, pixel};
    buf_we   = (state_q == DRAW) && (pixel != 4'd0);
  end

  // Next-state logic: request latch, two ROM fetches, then per-pixel stepping.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    attr_d  = attr_q;
    hflip_d = hflip_q;
    yrow_d  = yrow_q;
    step_d  = step_q;
    left_d  = left_q;
    right_d = right_q;
    acc_d   = acc_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dr_start) begin
          code_d  = code;
          attr_d  = attr;
          hflip_d = hflip;
          yrow_d  = ysub ^ {4{vflip}};
          step_d  = (hzoom[9:0] == 10'd0) ? 10'd1 : hzoom[9:0];
          cnt_d   = '0;
          if (hz_keep) begin
            // Resume the sprite: keep x, carry the fractional overshoot.
            acc_d = acc_q - 11'd1024;
          end else begin
            acc_d = '0;
            x_d   = BUFW'(hpos);
          end
          state_d = FETCH0;
        end
      end
      FETCH0: begin
        if (rom_ok) begin
          left_d  = rom_data;
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        if (rom_ok) begin
          right_d = rom_data;
          state_d = DRAW;
        end
      end
      DRAW: begin
        x_d   = x_q + BUFW'(1);
        acc_d = acc_sum;
        cnt_d = cnt_q + CNTW'(1);
        // Tile exhausted once the integer part passes 15, or enlargement cap hit.
        if (acc_sum[10] || last_pxl) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      attr_q  <= '0;
      hflip_q <= 1'b0;
      yrow_q  <= '0;
      step_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      attr_q  <= attr_d;
      hflip_q <= hflip_d;
      yrow_q  <= yrow_d;
      step_q  <= step_d;
      left_q  <= left_d;
      right_q <= right_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_jt053247_draw.sv
// Testbench for jt053247_draw: directed draw requests with a write scoreboard.
module tb_jt053247_draw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dr_start;
  logic        dr_busy;
  logic [15:0] code;
  logic [9:0]  attr;
  logic        hflip, vflip;
  logic [8:0]  hpos;
  logic [3:0]  ysub;
  logic [11:0] hzoom;
  logic        hz_keep;
  logic [20:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [8:0]  buf_addr;
  logic [13:0] buf_din;
  logic        buf_we;

  int n_checks = 0;
  int n_errors = 0;
  logic [22:0] exp_q[$];

  localparam logic [31:0] WL = 32'h12345678;
  localparam logic [31:0] WR = 32'h9ABCDEF0;

  jt053247_draw #(.BUFW(9), .MAXPXL(512)) dut (
    .clk(clk), .rst_n(rst_n), .dr_start(dr_start), .dr_busy(dr_busy),
    .code(code), .attr(attr), .hflip(hflip), .vflip(vflip), .hpos(hpos),
    .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [8:0] x, input logic [9:0] a, input logic [3:0] p);
    exp_q.push_back({x, a, p});
  endtask

  // Monitor: every line-buffer write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && buf_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'({buf_addr, buf_din}), 32'h7FFFFFFF);
      end else begin
        chk("write", 32'({buf_addr, buf_din}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic run_draw(input logic [15:0] c, input logic [9:0] a,
                          input logic hf, input logic vf, input logic [8:0] hp,
                          input logic [3:0] ys, input logic [11:0] hz, input logic keep,
                          input int dly, input int poke, input int rst_at,
                          input logic [20:0] a0, input logic [20:0] a1, input int exp_n);
    int cyc;
    code = c; attr = a; hflip = hf; vflip = vf; hpos = hp; ysub = ys;
    hzoom = hz; hz_keep = keep; dr_start = 1'b1;
    @(posedge clk); #1;
    dr_start = 1'b0;
    chk("busy_start", 32'(dr_busy), 32'd1);
    chk("cs_fetch0", 32'(rom_cs), 32'd1);
    chk("addr_fetch0", 32'(rom_addr), 32'(a0));
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("addr_hold", 32'(rom_addr), 32'(a0));
      chk("cs_hold", 32'(rom_cs), 32'd1);
      chk("we_hold", 32'(buf_we), 32'd0);
    end
    rom_data = WL; rom_ok = 1'b1;
    @(posedge clk); #1;
    chk("addr_fetch1", 32'(rom_addr), 32'(a1));
    chk("cs_fetch1", 32'(rom_cs), 32'd1);
    rom_data = WR;
    @(posedge clk); #1;
    rom_ok = 1'b0; rom_data = 32'h0;
    chk("cs_draw", 32'(rom_cs), 32'd0);
    cyc = 0;
    while (dr_busy && cyc < 700) begin
      dr_start = (cyc == poke);
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(buf_we), 32'd0);
        chk("rst_busy", 32'(dr_busy), 32'd0);
        chk("rst_cs", 32'(rom_cs), 32'd0);
        chk("rst_baddr", 32'(buf_addr), 32'd0);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    dr_start = 1'b0;
    if (rst_at < 0) chk("pixel_cycles", 32'(cyc), 32'(exp_n));
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", 32'(dr_busy), 32'd0);
      chk("idle_cs", 32'(rom_cs), 32'd0);
    end
    if (rst_at >= 0) begin
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int src;
    rst_n = 1'b0; dr_start = 1'b0; code = '0; attr = '0; hflip = 1'b0; vflip = 1'b0;
    hpos = '0; ysub = '0; hzoom = '0; hz_keep = 1'b0; rom_data = '0; rom_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(dr_busy), 32'd0);
    chk("reset_cs", 32'(rom_cs), 32'd0);
    chk("reset_we", 32'(buf_we), 32'd0);
    chk("reset_raddr", 32'(rom_addr), 32'd0);
    chk("reset_baddr", 32'(buf_addr), 32'd0);
    chk("reset_din", 32'(buf_din), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1:1 draw: pixels 1..F at 0x20..0x2E, transparent at 0x2F.
    for (int i = 0; i < 15; i++) push_w(9'(32'h20 + i), 10'h2A5, 4'(i + 1));
    run_draw(16'h1234, 10'h2A5, 1'b0, 1'b0, 9'h020, 4'd3, 12'h040, 1'b0,
             0, -1, -1, 21'h024686, 21'h024687, 16);

    // Both flips: row 12, transparent at 0x20, F..1 at 0x21..0x2F.
    for (int i = 1; i < 16; i++) push_w(9'(32'h20 + i), 10'h155, 4'(16 - i));
    run_draw(16'h1234, 10'h155, 1'b1, 1'b1, 9'h020, 4'd3, 12'h040, 1'b0,
             0, -1, -1, 21'h024698, 21'h024699, 16);

    // Shrink 2:1: source pixels 0,2,..,14 -> values 1,3,..,15.
    for (int k = 0; k < 8; k++) push_w(9'(32'h40 + k), 10'h001, 4'(2 * k + 1));
    run_draw(16'h00A0, 10'h001, 1'b0, 1'b0, 9'h040, 4'd0, 12'h080, 1'b0,
             0, -1, -1, 21'h001400, 21'h001401, 8);

    // Enlarge 1:2: each source pixel twice; source 15 is transparent.
    for (int k = 0; k < 30; k++) push_w(9'(32'h80 + k), 10'h3FF, 4'(k / 2 + 1));
    run_draw(16'hFFFF, 10'h3FF, 1'b0, 1'b0, 9'h080, 4'd15, 12'hC20, 1'b0,
             0, -1, -1, 21'h1FFFFE, 21'h1FFFFF, 32);

    // Zero step: capped at 512 pixels, x wraps 0x1FF -> 0x000.
    for (int k = 0; k < 512; k++) push_w(9'(32'h1F0 + k), 10'h0F0, 4'(k / 64 + 1));
    run_draw(16'h0001, 10'h0F0, 1'b0, 1'b0, 9'h1F0, 4'd1, 12'h000, 1'b0,
             0, -1, -1, 21'h000022, 21'h000023, 512);

    // Continuation: first tile 22 pixels (end acc 1056), second from x=0x116, acc=32.
    for (int k = 0; k < 22; k++) begin
      src = (48 * k) / 64;
      if (src < 15) push_w(9'(32'h100 + k), 10'h0AA, 4'(src + 1));
    end
    run_draw(16'h0002, 10'h0AA, 1'b0, 1'b0, 9'h100, 4'd0, 12'h030, 1'b0,
             0, -1, -1, 21'h000040, 21'h000041, 22);
    for (int k = 0; k < 21; k++) begin
      src = (32 + 48 * k) / 64;
      if (src < 15) push_w(9'(32'h116 + k), 10'h0AB, 4'(src + 1));
    end
    run_draw(16'h0003, 10'h0AB, 1'b0, 1'b0, 9'h000, 4'd0, 12'h030, 1'b1,
             0, -1, -1, 21'h000060, 21'h000061, 21);

    // Handshake: rom_ok withheld 5 cycles, dr_start pulsed mid-draw is ignored.
    for (int i = 0; i < 15; i++) push_w(9'(32'h20 + i), 10'h111, 4'(i + 1));
    run_draw(16'h1234, 10'h111, 1'b0, 1'b0, 9'h020, 4'd3, 12'h040, 1'b0,
             5, 3, -1, 21'h024686, 21'h024687, 16);

    // Reset mid-draw after four pixels.
    for (int i = 0; i < 4; i++) push_w(9'(32'h30 + i), 10'h222, 4'(i + 1));
    run_draw(16'h1234, 10'h222, 1'b0, 1'b0, 9'h030, 4'd3, 12'h040, 1'b0,
             0, -1, 4, 21'h024686, 21'h024687, 0);

    // Fresh request after reset.
    for (int i = 0; i < 15; i++) push_w(9'(32'h50 + i), 10'h333, 4'(i + 1));
    run_draw(16'h1234, 10'h333, 1'b0, 1'b0, 9'h050, 4'd3, 12'h040, 1'b0,
             0, -1, -1, 21'h024686, 21'h024687, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
